// File: rtl/chdr_8sc_to_16sc_if.sv
// CHDR streaming channel (64-bit data, last/valid/ready) shared by the
// sc8-to-sc16 converter and its bench.
interface chdr_8sc_to_16sc_if;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/chdr_8sc_to_16sc.sv
// Expands CHDR sc8 payloads to sc16, rewriting length and optionally the dest SID.
// Optional status counter on debug: define CHDR_8SC_TO_16SC_DEBUG_EN.
module chdr_8sc_to_16sc #(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        set_stb,
  input  logic [7:0]                  set_addr,
  input  logic [31:0]                 set_data,
  chdr_8sc_to_16sc_if.slave           i_chdr,
  chdr_8sc_to_16sc_if.master          o_chdr,
  output logic [31:0]                 debug
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_TIME = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  state_t             state;
  logic signed [17:0] rem;
  logic               sid_en;
  logic [15:0]        sid_dest;

  logic        has_time;
  logic [15:0] hdr_bytes;
  logic [15:0] pay_in;
  logic [15:0] out_len;
  logic [63:0] hdr_out;
  logic [63:0] lo_out;
  logic [63:0] hi_out;
  logic        final_lo;
  logic        xfer;

  logic unused_set_data;
  assign unused_set_data = &{1'b0, set_data[31:17]};

  assign has_time  = i_chdr.tdata[61];
  assign hdr_bytes = has_time ? 16'd16 : 16'd8;
  assign pay_in    = i_chdr.tdata[47:32] - hdr_bytes;
  assign out_len   = hdr_bytes + {pay_in[14:0], 1'b0};
  assign hdr_out   = {i_chdr.tdata[63:48], out_len, i_chdr.tdata[31:16],
                      sid_en ? sid_dest : i_chdr.tdata[15:0]};

  // Each 8-bit component becomes the top byte of a 16-bit lane (exact x<<8).
  assign lo_out = {i_chdr.tdata[63:56], 8'h00, i_chdr.tdata[55:48], 8'h00,
                   i_chdr.tdata[47:40], 8'h00, i_chdr.tdata[39:32], 8'h00};
  assign hi_out = {i_chdr.tdata[31:24], 8'h00, i_chdr.tdata[23:16], 8'h00,
                   i_chdr.tdata[15:8],  8'h00, i_chdr.tdata[7:0],   8'h00};

  assign final_lo      = i_chdr.tlast && (rem <= 18'sd4);
  assign o_chdr.tvalid = i_chdr.tvalid && reset_n;
  assign xfer          = o_chdr.tvalid && o_chdr.tready;

  always_comb begin
    o_chdr.tdata  = i_chdr.tdata;
    o_chdr.tlast  = 1'b0;
    i_chdr.tready = 1'b0;
    case (state)
      ST_HDR: begin
        o_chdr.tdata  = hdr_out;
        o_chdr.tlast  = i_chdr.tlast;
        i_chdr.tready = o_chdr.tready;
      end
      ST_TIME: begin
        o_chdr.tlast  = i_chdr.tlast;
        i_chdr.tready = o_chdr.tready;
      end
      ST_LO: begin
        o_chdr.tdata = lo_out;
        if (final_lo) begin
          o_chdr.tlast  = 1'b1;
          i_chdr.tready = o_chdr.tready;
        end
      end
      default: begin
        o_chdr.tdata  = hi_out;
        o_chdr.tlast  = i_chdr.tlast;
        i_chdr.tready = o_chdr.tready;
      end
    endcase
    if (!reset_n) begin
      o_chdr.tlast  = 1'b0;
      i_chdr.tready = 1'b0;
    end
  end

  // rem is only a hint for the short final word; i_tlast always ends the packet.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_HDR;
      rem      <= '0;
      sid_en   <= 1'b0;
      sid_dest <= '0;
    end else begin
      if (set_stb && (set_addr == BASE)) begin
        sid_en   <= set_data[16];
        sid_dest <= set_data[15:0];
      end
      if (xfer) begin
        case (state)
          ST_HDR: begin
            rem <= $signed({2'b00, pay_in});
            if (i_chdr.tlast)  state <= ST_HDR;
            else if (has_time) state <= ST_TIME;
            else               state <= ST_LO;
          end
          ST_TIME: state <= i_chdr.tlast ? ST_HDR : ST_LO;
          ST_LO:   state <= final_lo ? ST_HDR : ST_HI;
          default: begin
            if (rem > 18'sd0) rem <= rem - 18'sd8;
            state <= i_chdr.tlast ? ST_HDR : ST_LO;
          end
        endcase
      end
    end
  end

`ifdef CHDR_8SC_TO_16SC_DEBUG_EN
  logic [23:0] pkt_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)                   pkt_cnt <= '0;
    else if (xfer && o_chdr.tlast)  pkt_cnt <= pkt_cnt + 24'd1;
  end

  assign debug = reset_n ? {state, sid_en, 5'b0, pkt_cnt} : 32'h0;
`else
  assign debug = 32'h0;
`endif

endmodule

// File: tb/tb_chdr_8sc_to_16sc.sv
// Directed bench for chdr_8sc_to_16sc: expected output beats are queued by the
// stimulus and compared by a monitor on the falling edge.
module tb_chdr_8sc_to_16sc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] debug;
  logic        bp_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [64:0] exp_q[$];
  string       tag_q[$];

  chdr_8sc_to_16sc_if in_if ();
  chdr_8sc_to_16sc_if out_if ();

  chdr_8sc_to_16sc #(.BASE(8'd0)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_chdr   (in_if),
    .o_chdr   (out_if),
    .debug    (debug)
  );

  always #5 clk = ~clk;

  // Downstream ready: always on, or random stalls when backpressure is enabled.
  always @(posedge clk) begin
    out_if.tready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every accepted output beat must match the next queued expectation.
  always @(negedge clk) begin
    if (out_if.tvalid && out_if.tready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("[TB] FAIL unexpected_beat observed=%h expected=none", {out_if.tlast, out_if.tdata});
      end else begin
        automatic logic [64:0] e = exp_q.pop_front();
        automatic string       t = tag_q.pop_front();
        checkOutput(t, {out_if.tlast, out_if.tdata}, e);
      end
    end
  end

  task automatic pushExp(input string tag, input logic last, input logic [63:0] data);
    exp_q.push_back({last, data});
    tag_q.push_back(tag);
  endtask

  // Presents one input word until accepted; counts cycles where the output
  // moved but the input word was held.
  task automatic applyStimulus(input logic [63:0] data, input logic last, output int stalls);
    logic accepted;
    accepted      = 1'b0;
    stalls        = 0;
    in_if.tdata   = data;
    in_if.tlast   = last;
    in_if.tvalid  = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (out_if.tvalid && out_if.tready && !in_if.tready) stalls++;
      if (in_if.tready) begin
        accepted = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
    end
    checkOutput("accept_timeout", 65'(accepted), 65'(1'b1));
  endtask

  task automatic idle(input int cycles);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic setReg(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk);
    #1;
    set_stb  = 1'b0;
  endtask

  function automatic logic [63:0] mkword(input int k, input int w);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = 8'(k*32 + w*8 + j + 1);
    return r;
  endfunction

  function automatic logic [63:0] expand(input logic [63:0] w, input bit hi);
    logic [31:0] s;
    s = hi ? w[31:0] : w[63:32];
    return {s[31:24], 8'h00, s[23:16], 8'h00, s[15:8], 8'h00, s[7:0], 8'h00};
  endfunction

  initial begin
    int st;
    int sizes[9];
    int nout[9];
    sizes = '{2, 4, 6, 8, 10, 12, 14, 16, 32};
    nout  = '{1, 1, 2, 2, 3, 3, 4, 4, 8};

    reset_n      = 1'b0;
    set_stb      = 1'b0;
    set_addr     = 8'h00;
    set_data     = 32'h0;
    in_if.tdata  = 64'h2005_0012_DEAD_BEEF;
    in_if.tlast  = 1'b1;
    in_if.tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_o_tvalid", 65'(out_if.tvalid), 65'(1'b0));
    checkOutput("rst_i_tready", 65'(in_if.tready), 65'(1'b0));
    checkOutput("rst_o_tlast",  65'(out_if.tlast), 65'(1'b0));
    checkOutput("rst_debug",    65'(debug), 65'(32'h0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    $display("[TB] SID override with timestamp");
    setReg(8'h00, 32'h0001_FEED);
    pushExp("sid_hdr",  1'b0, 64'h2005_0014_DEAD_FEED);
    pushExp("sid_time", 1'b0, 64'h0000_0000_0000_0000);
    pushExp("sid_pay",  1'b1, 64'h1200_3400_0000_0000);
    applyStimulus(64'h2005_0012_DEAD_BEEF, 1'b0, st);
    checkOutput("sid_hdr_stall", 65'(st), 65'(0));
    applyStimulus(64'h0000_0000_0000_0000, 1'b0, st);
    applyStimulus(64'h1234_0000_0000_0000, 1'b1, st);
    checkOutput("sid_pay_stall", 65'(st), 65'(0));
    idle(3);
    setReg(8'h00, 32'h0000_0000);
    setReg(8'h01, 32'h0001_1111);

    $display("[TB] four samples, two output words");
    pushExp("s8_hdr",  1'b0, 64'h2001_0020_0102_0304);
    pushExp("s8_time", 1'b0, 64'h1111_2222_3333_4444);
    pushExp("s8_lo",   1'b0, 64'h0100_0200_0300_0400);
    pushExp("s8_hi",   1'b1, 64'h0500_0600_0700_0800);
    applyStimulus(64'h2001_0018_0102_0304, 1'b0, st);
    applyStimulus(64'h1111_2222_3333_4444, 1'b0, st);
    checkOutput("s8_time_stall", 65'(st), 65'(0));
    applyStimulus(64'h0102_0304_0506_0708, 1'b1, st);
    checkOutput("s8_pay_stall", 65'(st), 65'(1));
    idle(3);

    $display("[TB] payload size sweep");
    for (int k = 0; k < 9; k++) begin
      int p;
      int nin;
      p   = sizes[k];
      nin = (nout[k] + 1) / 2;
      pushExp("sw_hdr", 1'b0, {4'h2, 12'(k + 16), 16'(16 + 2*p), 32'hC0DE_0000 + 32'(k)});
      pushExp("sw_time", 1'b0, 64'(k));
      for (int o = 0; o < nout[k]; o++)
        pushExp("sw_pay", (o == nout[k] - 1), expand(mkword(k, o/2), (o % 2) == 1));
      applyStimulus({4'h2, 12'(k + 16), 16'(16 + p), 32'hC0DE_0000 + 32'(k)}, 1'b0, st);
      applyStimulus(64'(k), 1'b0, st);
      for (int w = 0; w < nin; w++) begin
        int halves;
        halves = (nout[k] - 2*w >= 2) ? 2 : 1;
        applyStimulus(mkword(k, w), (w == nin - 1), st);
        checkOutput("sw_stall", 65'(st), 65'((halves == 2) ? 1 : 0));
      end
      idle(2);
    end
    checkOutput("sw_drain", 65'(exp_q.size()), 65'(0));
`ifdef CHDR_8SC_TO_16SC_DEBUG_EN
    checkOutput("dbg_pkt_cnt", 65'(debug[23:0]), 65'(24'd11));
`else
    checkOutput("dbg_tied_zero", 65'(debug), 65'(32'h0));
`endif

    $display("[TB] negative samples and odd payload");
    pushExp("neg_hdr", 1'b0, 64'h0003_000C_AAAA_5555);
    pushExp("neg_pay", 1'b1, 64'h8000_FF00_0000_0000);
    applyStimulus(64'h0003_000A_AAAA_5555, 1'b0, st);
    applyStimulus(64'h80FF_0000_0000_0000, 1'b1, st);
    pushExp("odd_hdr", 1'b0, 64'h0004_000E_0000_0001);
    pushExp("odd_pay", 1'b1, 64'hAA00_BB00_CC00_0000);
    applyStimulus(64'h0004_000B_0000_0001, 1'b0, st);
    applyStimulus(64'hAABB_CC00_0000_0000, 1'b1, st);
    checkOutput("odd_pay_stall", 65'(st), 65'(0));
    pushExp("mal_hdr", 1'b1, 64'h0006_0008_0000_0002);
    applyStimulus(64'h0006_0008_0000_0002, 1'b1, st);
    idle(2);

    $display("[TB] random backpressure");
    bp_en = 1'b1;
    pushExp("bp_hdr", 1'b0, 64'h0005_0018_00AB_00CD);
    pushExp("bp_lo",  1'b0, 64'h0100_0200_0300_0400);
    pushExp("bp_hi",  1'b1, 64'h0500_0600_0700_0800);
    applyStimulus(64'h0005_0010_00AB_00CD, 1'b0, st);
    applyStimulus(64'h0102_0304_0506_0708, 1'b1, st);
    checkOutput("bp_pay_stall", 65'(st), 65'(1));
    pushExp("bpt_hdr",  1'b0, 64'h2001_0020_0102_0304);
    pushExp("bpt_time", 1'b0, 64'h1111_2222_3333_4444);
    pushExp("bpt_lo",   1'b0, 64'h0100_0200_0300_0400);
    pushExp("bpt_hi",   1'b1, 64'h0500_0600_0700_0800);
    applyStimulus(64'h2001_0018_0102_0304, 1'b0, st);
    applyStimulus(64'h1111_2222_3333_4444, 1'b0, st);
    applyStimulus(64'h0102_0304_0506_0708, 1'b1, st);
    checkOutput("bpt_pay_stall", 65'(st), 65'(1));
    idle(4);
    bp_en = 1'b0;
    idle(2);

    $display("[TB] reset in the high half of a payload word");
    pushExp("rh_hdr", 1'b0, 64'h0007_0028_1234_5678);
    pushExp("rh_lo",  1'b0, 64'h1100_2200_3300_4400);
    applyStimulus(64'h0007_0018_1234_5678, 1'b0, st);
    in_if.tdata  = 64'h1122_3344_5566_7788;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b1;
    @(negedge clk);
    checkOutput("rh_lo_ready", 65'(in_if.tready), 65'(1'b0));
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rh_o_tvalid", 65'(out_if.tvalid), 65'(1'b0));
    checkOutput("rh_i_tready", 65'(in_if.tready), 65'(1'b0));
    checkOutput("rh_o_tlast",  65'(out_if.tlast), 65'(1'b0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    in_if.tvalid = 1'b0;
    idle(1);
    pushExp("ra_hdr", 1'b0, 64'h0008_0018_0000_0009);
    pushExp("ra_lo",  1'b0, 64'h0100_0200_0300_0400);
    pushExp("ra_hi",  1'b1, 64'h0500_0600_0700_0800);
    applyStimulus(64'h0008_0010_0000_0009, 1'b0, st);
    applyStimulus(64'h0102_0304_0506_0708, 1'b1, st);
    idle(3);
    checkOutput("final_drain", 65'(exp_q.size()), 65'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
